// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 serial receiver with one-byte valid/ready holding buffer
// Ports:
//    clk       - system clock, all logic on rising edge
//    rst_n     - synchronous active-low reset
//    rx        - raw serial input, idle high, asynchronous to clk
//    rx_data   - received byte, valid while rx_valid is high
//    rx_valid  - holding register full
//    rx_ready  - consumer accepts rx_data when rx_valid && rx_ready
//    frame_err - one-cycle pulse, stop bit sampled low, byte discarded
//    overrun   - one-cycle pulse, byte completed while buffer full, byte dropped
//    busy      - high whenever the receiver is not idle
module uart_rx_deframer #(
   parameter int CLK_DIV = 434,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLK_DIV / 2 - 1);

   logic             r_sync1, r_sync2;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shreg;
   logic [7:0]       r_data;
   logic             r_valid, r_ferr, r_ovr, r_busy;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_cnt_last, w_cnt_half, w_done, w_commit, w_load, w_consume;

   assign w_cnt_last = (r_cnt == C_LAST);
   assign w_cnt_half = (r_cnt == C_HALF);
   // completion event: mid stop bit; r_sync2 is the synchronised line level
   assign w_done     = (r_state == S_STOP) && w_cnt_last;
   assign w_commit   = w_done && r_sync2;
   assign w_consume  = r_valid && rx_ready;
   // a byte may land in the buffer if it is empty or being drained this cycle
   assign w_load     = w_commit && (!r_valid || rx_ready);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (!r_sync2) w_state_nxt = S_START;
         end
         S_START: if (w_cnt_half) begin
            w_cnt_nxt   = '0;
            w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
         end
         S_DATA: if (w_cnt_last) begin
            w_cnt_nxt   = '0;
            if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
         end
         default: if (w_cnt_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_cnt   <= w_cnt_nxt;
         if (r_state == S_START) r_bit_idx <= '0;
         // LSB arrives first, so shift in at the MSB
         if (r_state == S_DATA && w_cnt_last) begin
            r_shreg   <= {r_sync2, r_shreg[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         r_ferr <= w_done && !r_sync2;
         r_ovr  <= w_commit && !w_load;
         if (w_load) begin
            r_data  <= r_shreg;
            r_valid <= 1'b1;
         end else if (w_consume) r_valid <= 1'b0;
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;
   assign busy      = r_busy;
endmodule
